// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream (count, little-endian words, XOR checksum),
// writes each word into instruction memory and releases the CPU only after the checksum verifies.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              PCen,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [31:0] CAP = 32'(1) << ADDR_W;

    state_t            state, state_nx;
    logic [7:0]        n_lo;
    logic [15:0]       n;
    logic [1:0]        bcnt;
    logic [23:0]       asm_q;
    logic [ADDR_W-1:0] widx;
    logic [7:0]        csum;
    logic              xfer;
    logic [15:0]       hdr_n;
    logic              hdr_big;
    logic              last_word;

    // Handshake: a byte moves when byte_valid and byte_ready are both 1 at a rising edge;
    // byte_ready never depends on byte_valid, and byte_data is ignored otherwise.
    assign xfer      = byte_valid & byte_ready;
    assign hdr_n     = {byte_data, n_lo};
    assign hdr_big   = 32'(hdr_n) > CAP;
    assign last_word = 32'(widx) == (32'(n) - 32'd1);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            HDR_LO: if (xfer) state_nx = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    if (hdr_big)             state_nx = ERROR;
                    else if (hdr_n == 16'd0) state_nx = CSUM;
                    else                     state_nx = DATA;
                end
            end
            DATA:   if (xfer && bcnt == 2'd3 && last_word) state_nx = CSUM;
            CSUM:   if (xfer) state_nx = (byte_data == csum) ? RUN : ERROR;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HDR_LO;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            PCen       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            n_lo       <= '0;
            n          <= '0;
            bcnt       <= '0;
            asm_q      <= '0;
            widx       <= '0;
            csum       <= '0;
        end else begin
            state      <= state_nx;
            // Ready is registered from the next state so it drops on the same edge RUN/ERROR is entered.
            byte_ready <= (state_nx == HDR_LO) || (state_nx == HDR_HI) ||
                          (state_nx == DATA)   || (state_nx == CSUM);
            imem_we    <= 1'b0;
            if (state == RUN) begin
                done <= 1'b1;
                PCen <= 1'b1;
            end
            if (state == ERROR) err <= 1'b1;
            if (xfer) begin
                case (state)
                    HDR_LO: n_lo <= byte_data;
                    HDR_HI: n    <= hdr_n;
                    DATA: begin
                        bcnt <= bcnt + 2'd1;
                        csum <= csum ^ byte_data;
                        case (bcnt)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= widx;
                                imem_wdata <= {byte_data, asm_q};
                                widx       <= widx + ADDR_W'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scripted and random loads, expected writes queued as bytes are driven
// and popped when the memory write strobe fires.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              PCen;
    logic              done;
    logic              err;
    logic [2:0]        state_dbg;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        words[256];
    int                 errors = 0;
    int                 checks = 0;
    int                 max_gap = 0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .PCen(PCen), .done(done), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e[ADDR_W+31:32]));
                check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    // driver tasks: all are entered and left on a falling edge
    task automatic send_byte(input logic [7:0] b);
        int t;
        int gap;
        t = 0;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 0, 1);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic send_load(input int n, input bit bad);
        logic [7:0]  cs;
        logic [15:0] nn;
        logic [7:0]  b;
        cs = 8'h00;
        nn = 16'(n);
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ADDR_W'(i), words[i]});
            for (int k = 0; k < 4; k++) begin
                b = words[i][8*k +: 8];
                cs = cs ^ b;
                send_byte(b);
            end
            check("we_latency", 64'(imem_we), 1);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs);
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (!(done || err) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(done || err)) check("result_timeout", 0, 1);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_done"}, 64'(done), 1);
        check({tag, "_pcen"}, 64'(PCen), 1);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_ready"}, 64'(byte_ready), 0);
        check({tag, "_q_empty"}, 64'(exp_q.size()), 0);
    endtask

    task automatic check_error(input string tag);
        check({tag, "_err"}, 64'(err), 1);
        check({tag, "_pcen"}, 64'(PCen), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_ready"}, 64'(byte_ready), 0);
        check({tag, "_q_empty"}, 64'(exp_q.size()), 0);
    endtask

    task automatic offer_locked(input string tag);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (6) @(negedge clk);
        check({tag, "_ready"}, 64'(byte_ready), 0);
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(byte_ready), 0);
        check("rst_we", 64'(imem_we), 0);
        check("rst_addr", 64'(imem_addr), 0);
        check("rst_wdata", 64'(imem_wdata), 0);
        check("rst_pcen", 64'(PCen), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_state", 64'(state_dbg), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(byte_ready), 1);

        // normal load
        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        send_load(2, 1'b0);
        wait_result();
        check_run("normal");

        // bad checksum
        do_reset();
        send_load(2, 1'b1);
        wait_result();
        check_error("badcs");

        // empty load
        do_reset();
        send_load(0, 1'b0);
        wait_result();
        check_run("empty");

        // oversize header (N = 257) and lockout
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        byte_valid = 1'b0;
        wait_result();
        check_error("oversize");
        offer_locked("oversize_lock");

        // abort after six bytes: the first word has been written, then reset clears everything
        do_reset();
        exp_q.push_back({ADDR_W'(0), words[0]});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        byte_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("abort_we", 64'(imem_we), 0);
        check("abort_addr", 64'(imem_addr), 0);
        check("abort_wdata", 64'(imem_wdata), 0);
        check("abort_ready", 64'(byte_ready), 0);
        check("abort_state", 64'(state_dbg), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_load(2, 1'b0);
        wait_result();
        check_run("after_abort");

        // throttled stream, then bytes offered in RUN
        do_reset();
        max_gap = 3;
        send_load(2, 1'b0);
        max_gap = 0;
        wait_result();
        check_run("throttle");
        offer_locked("run_lock");

        // random small load
        do_reset();
        n = int'($urandom_range(6, 1));
        for (int i = 0; i < n; i++) words[i] = $urandom;
        max_gap = 1;
        send_load(n, 1'b0);
        max_gap = 0;
        wait_result();
        check_run("random");

        // full memory: N = 2^ADDR_W
        do_reset();
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        send_load(256, 1'b0);
        wait_result();
        check_run("full");
        offer_locked("full_lock");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
